// File: rtl/out_controller.sv
// Read-out sequencer for the matrix multiplier result bank: walks rd_sel 1..NUM_OUT,
// streams each word on a valid/ready port, then clears the bank and pulses done.
//
// state | meaning
// IDLE  | waiting for start, rd_sel=0
// FETCH | rd_sel=idx, capture res_data into out_data
// SEND  | out_data offered downstream until accepted
// CLEAR | one-cycle clr_res/done pulse
module out_controller #(
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 3,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] res_data,
  output logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              clr_res,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, CLEAR} state_t;

  localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (out_ready) state_nxt = (idx == LAST_IDX) ? CLEAR : FETCH;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx saturates at LAST_IDX; the word after the last one is CLEAR, never a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      out_data <= '0;
    end else begin
      if (state == IDLE && start)
        idx <= FIRST_IDX;
      else if (state == SEND && out_ready && idx != LAST_IDX)
        idx <= idx + 1'b1;
      if (state == FETCH)
        out_data <= res_data;
    end
  end

  always_comb begin
    rd_sel    = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    clr_res   = 1'b0;
    done      = 1'b0;
    case (state)
      FETCH: rd_sel = idx;
      SEND: begin
        rd_sel    = idx;
        out_valid = 1'b1;
        out_last  = (idx == LAST_IDX);
      end
      CLEAR: begin
        clr_res = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_out_controller.sv
// Bench for out_controller: two instances (NUM_OUT=4 and NUM_OUT=9) driven with shared
// directed and random stimulus, checked every cycle against a word-level reference model.
module tb_out_controller;

  logic clk = 1'b0;
  logic reset, start, out_ready;

  logic [15:0] bank [16];

  logic [2:0]  rd_sel0;
  logic [3:0]  rd_sel1;
  logic [15:0] res_data0, res_data1, out_data0, out_data1;
  logic out_valid0, out_last0, busy0, clr_res0, done0;
  logic out_valid1, out_last1, busy1, clr_res1, done1;

  assign res_data0 = bank[{1'b0, rd_sel0}];
  assign res_data1 = bank[rd_sel1];

  out_controller #(.NUM_OUT(4), .SEL_W(3), .DATA_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .res_data(res_data0), .rd_sel(rd_sel0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .busy(busy0), .clr_res(clr_res0), .done(done0));

  out_controller #(.NUM_OUT(9), .SEL_W(4), .DATA_W(16)) u_dut9 (
    .clk(clk), .reset(reset), .start(start), .res_data(res_data1), .rd_sel(rd_sel1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .busy(busy1), .clr_res(clr_res1), .done(done1));

  always #5 clk = ~clk;

  logic [3:0]  o_sel [2];
  logic [15:0] o_dat [2];
  logic [4:0]  o_flg [2];  // {valid, last, busy, clr_res, done}
  assign o_sel[0] = {1'b0, rd_sel0};
  assign o_sel[1] = rd_sel1;
  assign o_dat[0] = out_data0;
  assign o_dat[1] = out_data1;
  assign o_flg[0] = {out_valid0, out_last0, busy0, clr_res0, done0};
  assign o_flg[1] = {out_valid1, out_last1, busy1, clr_res1, done1};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run is "active", presents word m_word once fetched, and
  // finishes with one clear cycle. Expected stream is queued at the accepted start.
  int          nout [2] = '{4, 9};
  bit          m_act [2], m_pres [2], m_fin [2];
  int          m_word [2];
  logic [15:0] m_data [2];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  bit          p_valid [2];
  logic [15:0] p_data [2];
  int          acc_cnt [2], done_cnt [2];
  bit          p_busy0;
  int          busy_len, last_len;

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i]  = 1'b0;
      m_pres[i] = 1'b0;
      m_fin[i]  = 1'b0;
      m_word[i] = 0;
      m_data[i] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i]  = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] e;
    int          depth;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (p_valid[i] && out_ready) acc_cnt[i]++;
      if (!m_act[i]) begin
        if (start) begin
          m_act[i]  = 1'b1;
          m_word[i] = 1;
          m_pres[i] = 1'b0;
          for (int k = 1; k <= nout[i]; k++)
            if (i == 0) q0.push_back(bank[k]);
            else        q1.push_back(bank[k]);
        end
      end else if (m_fin[i]) begin
        m_act[i] = 1'b0;
        m_fin[i] = 1'b0;
      end else if (!m_pres[i]) begin
        m_pres[i] = 1'b1;
        m_data[i] = bank[m_word[i]];
      end else if (out_ready) begin
        depth = (i == 0) ? q0.size() : q1.size();
        check($sformatf("sb_empty[%0d]", i), int'(depth == 0), 0);
        if (depth > 0) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("word%0d[%0d]", m_word[i], i), p_data[i], e);
        end
        m_pres[i] = 1'b0;
        if (m_word[i] < nout[i]) m_word[i]++;
        else begin
          m_fin[i] = 1'b1;
          check($sformatf("sb_left[%0d]", i), (i == 0) ? q0.size() : q1.size(), 0);
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rd_sel[%0d]", i), o_sel[i], (m_act[i] && !m_fin[i]) ? m_word[i] : 0);
      check($sformatf("out_data[%0d]", i), o_dat[i], m_data[i]);
      check($sformatf("out_valid[%0d]", i), o_flg[i][4], m_pres[i]);
      check($sformatf("out_last[%0d]", i), o_flg[i][3], m_pres[i] && m_word[i] == nout[i]);
      check($sformatf("busy[%0d]", i), o_flg[i][2], m_act[i]);
      check($sformatf("clr_res[%0d]", i), o_flg[i][1], m_fin[i]);
      check($sformatf("done[%0d]", i), o_flg[i][0], m_fin[i]);
      if (o_flg[i][0]) done_cnt[i]++;
      p_valid[i] = o_flg[i][4];
      p_data[i]  = o_dat[i];
    end
    if (busy0) busy_len++;
    else if (p_busy0) begin
      last_len = busy_len;
      busy_len = 0;
    end
    p_busy0 = busy0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic new_bank();
    bank[0] = '0;
    for (int k = 1; k < 16; k++) bank[k] = 16'($urandom);
  endtask

  task automatic expect_run(string tag, int w0, int d0, int w1, int d1);
    check({tag, "_words0"}, acc_cnt[0], w0);
    check({tag, "_dones0"}, done_cnt[0], d0);
    check({tag, "_words1"}, acc_cnt[1], w1);
    check({tag, "_dones1"}, done_cnt[1], d1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    p_busy0 = 1'b0; busy_len = 0; last_len = 0;
    for (int i = 0; i < 2; i++) begin p_valid[i] = 1'b0; p_data[i] = '0; end
    new_bank();
    model_reset();
    clr_cnt();

    // reset then idle
    repeat (2) cycle();
    reset = 1'b0;
    repeat (2) cycle();

    // nominal run with A1..D4
    bank[1] = 16'h00A1; bank[2] = 16'h00B2; bank[3] = 16'h00C3; bank[4] = 16'h00D4;
    clr_cnt();
    start = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (25) cycle();
    expect_run("nominal", 4, 1, 9, 1);
    check("nominal_busy_len0", last_len, 9);

    // backpressure on word 2 for 5 cycles
    new_bank();
    clr_cnt();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (30) cycle();
    expect_run("backpressure", 4, 1, 9, 1);
    check("backpressure_busy_len0", last_len, 14);

    // start held high across SEND and CLEAR: only IDLE-cycle starts count
    new_bank();
    clr_cnt();
    start = 1'b1;
    repeat (25) cycle();
    start = 1'b0;
    repeat (30) cycle();
    expect_run("start_busy", 12, 3, 18, 2);

    // async reset during SEND of word 3
    clr_cnt();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    check("pre_reset_sel0", rd_sel0, 3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare();
    cycle();
    reset = 1'b0;
    cycle();
    expect_run("reset_mid", 2, 0, 2, 0);
    clr_cnt();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (25) cycle();
    expect_run("after_reset", 4, 1, 9, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!m_act[0] && !m_act[1] && !reset) new_bank();
      start     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (30) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
